gen_fip_sign_vec_mac: RTL and testbench

// - Sequential signed fixed-point vector engine; successor to the single-shot gen_fip_sign_mult/adder/dist blocks.
// - Consumes VEC_LEN element pairs (num1[k], num2[k]) over a valid/ready stream.
// - Returns either dot product sum(num1*num2) or squared distance sum((num1-num2)^2) in one accumulated fixed-point word.
// - 3-stage pipeline (prep, multiply, accumulate); used by higher-level distance/score logic.

---
 rtl/gen_fip_sign_vec_mac.sv | 202 ++++++++++++++++++++
 tb/tb_gen_fip_sign_vec_mac.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gen_fip_sign_vec_mac.sv
// Sequential signed fixed-point vector MAC: dot product or squared distance over VEC_LEN pairs.
// Optional output saturation enabled by defining GEN_FIP_MAC_SAT_EN (default: two's-complement wrap).
module gen_fip_sign_vec_mac #(
    parameter int IN_INT_W    = 1,
    parameter int IN_FRACT_W  = 5,
    parameter int VEC_LEN     = 8,
    parameter int RES_INT_W   = 2*(IN_INT_W+1) + $clog2(VEC_LEN+1),
    localparam int IN_W        = IN_INT_W + IN_FRACT_W,
    localparam int RES_FRACT_W = 2*IN_FRACT_W,
    localparam int RES_W       = RES_INT_W + RES_FRACT_W
) (
    input  logic             clk,
    input  logic             sw_rst,
    input  logic             i_start_pls,
    input  logic             i_mode,
    input  logic             i_vld,
    input  logic [IN_W-1:0]  i_num1,
    input  logic [IN_W-1:0]  i_num2,
    output logic             o_rdy,
    output logic             o_busy,
    output logic             o_done_pls,
    output logic [RES_W-1:0] o_res,
    output logic             o_ovf
);

    localparam int OP_W   = IN_W + 1;
    localparam int PROD_W = 2*OP_W;
    localparam int ACC_W  = PROD_W + $clog2(VEC_LEN+1);
    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN-1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                     w_start;
    logic                     w_accept;
    logic                     w_fin;
    logic                     r_mode;
    logic [CNT_W-1:0]         r_cnt;

    logic [OP_W-1:0]          w_n1;
    logic [OP_W-1:0]          w_n2;
    logic [OP_W-1:0]          w_diff;

    logic                     r_s1_vld;
    logic signed [OP_W-1:0]   r_a;
    logic signed [OP_W-1:0]   r_b;
    logic                     r_s2_vld;
    logic signed [PROD_W-1:0] r_p;
    logic signed [ACC_W-1:0]  r_acc;

    logic [RES_W-1:0]         w_res;
    logic                     w_ovf;
    logic [RES_W-1:0]         r_res;
    logic                     r_ovf;

    assign w_start  = (r_state == S_IDLE)  && i_start_pls;
    assign w_accept = (r_state == S_ACCUM) && i_vld;
    assign w_fin    = (r_state == S_DRAIN) && !r_s1_vld && !r_s2_vld;

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_rdy       = 1'b0;
        o_busy      = 1'b1;
        o_done_pls  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start_pls) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                o_rdy = 1'b1;
                if (i_vld && (r_cnt == LAST_IDX)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_s1_vld && !r_s2_vld) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done_pls  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_cnt  <= '0;
            r_mode <= 1'b0;
        end else if (w_start) begin
            r_cnt  <= '0;
            r_mode <= i_mode;
        end else if (w_accept) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // One guard bit keeps the difference of two IN_W operands exact.
    assign w_n1   = {i_num1[IN_W-1], i_num1};
    assign w_n2   = {i_num2[IN_W-1], i_num2};
    assign w_diff = w_n1 - w_n2;

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_s1_vld <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                if (r_mode) begin
                    r_a <= w_diff;
                    r_b <= w_diff;
                end else begin
                    r_a <= w_n1;
                    r_b <= w_n2;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_s2_vld <= 1'b0;
            r_p      <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_p <= PROD_W'(r_a) * PROD_W'(r_b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_acc <= '0;
        end else if (w_start) begin
            r_acc <= '0;
        end else if (r_s2_vld) begin
            r_acc <= r_acc + ACC_W'(r_p);
        end
    end

`ifdef GEN_FIP_MAC_SAT_EN
    localparam int EXT_W = (ACC_W > RES_W) ? ACC_W : RES_W;
    logic signed [EXT_W-1:0] w_acc_ext;
    logic [EXT_W-RES_W:0]    w_hi;

    // The value fits RES_W exactly when every bit from RES_W-1 upward equals the sign.
    assign w_acc_ext = EXT_W'(r_acc);
    assign w_hi      = w_acc_ext[EXT_W-1:RES_W-1];
    assign w_ovf     = !((&w_hi) || !(|w_hi));
    assign w_res     = !w_ovf ? w_acc_ext[RES_W-1:0] :
                       w_acc_ext[EXT_W-1] ? {1'b1, {(RES_W-1){1'b0}}} :
                                            {1'b0, {(RES_W-1){1'b1}}};
`else
    assign w_res = RES_W'(r_acc);
    assign w_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_res <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_start) begin
                r_ovf <= 1'b0;
            end
            if (w_fin) begin
                r_res <= w_res;
                r_ovf <= w_ovf;
            end
        end
    end

    assign o_res = r_res;
    assign o_ovf = r_ovf;

endmodule

// File: tb/tb_gen_fip_sign_vec_mac.sv
// Bench for gen_fip_sign_vec_mac in Q1.5, VEC_LEN=4; a lossless and a narrow (RES_INT_W=3) instance share stimulus.
module tb_gen_fip_sign_vec_mac;

    localparam int W_M = 17;
    localparam int W_N = 13;

    logic           clk = 1'b0;
    logic           sw_rst;
    logic           i_start_pls;
    logic           i_mode;
    logic           i_vld;
    logic [5:0]     i_num1;
    logic [5:0]     i_num2;
    logic           o_rdy, o_busy, o_done_pls, o_ovf;
    logic [W_M-1:0] o_res;
    logic           n_rdy, n_busy, n_done_pls, n_ovf;
    logic [W_N-1:0] n_res;

    int n_chk  = 0;
    int n_fail = 0;
    int e1[4];
    int e2[4];
    logic [31:0] prev_m;

    always #5 clk = ~clk;

    gen_fip_sign_vec_mac #(.IN_INT_W(1), .IN_FRACT_W(5), .VEC_LEN(4)) u_dut (
        .clk(clk), .sw_rst(sw_rst), .i_start_pls(i_start_pls), .i_mode(i_mode),
        .i_vld(i_vld), .i_num1(i_num1), .i_num2(i_num2), .o_rdy(o_rdy),
        .o_busy(o_busy), .o_done_pls(o_done_pls), .o_res(o_res), .o_ovf(o_ovf)
    );

    gen_fip_sign_vec_mac #(.IN_INT_W(1), .IN_FRACT_W(5), .VEC_LEN(4), .RES_INT_W(3)) u_nar (
        .clk(clk), .sw_rst(sw_rst), .i_start_pls(i_start_pls), .i_mode(i_mode),
        .i_vld(i_vld), .i_num1(i_num1), .i_num2(i_num2), .o_rdy(n_rdy),
        .o_busy(n_busy), .o_done_pls(n_done_pls), .o_res(n_res), .o_ovf(n_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Fit an exact result into a w-bit signed word: clamp or wrap depending on the build.
    function automatic logic [31:0] reduce(input longint s, input int w, output logic ovf);
        longint      maxv;
        longint      minv;
        longint      r;
        logic [31:0] mask;
        maxv = (longint'(1) << (w-1)) - 1;
        minv = -(longint'(1) << (w-1));
        mask = (32'h1 << w) - 32'h1;
        ovf  = 1'b0;
        r    = s;
`ifdef GEN_FIP_MAC_SAT_EN
        if (s > maxv) begin
            r = maxv; ovf = 1'b1;
        end else if (s < minv) begin
            r = minv; ovf = 1'b1;
        end
`endif
        return 32'(r) & mask;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_rdy"},  {31'd0, o_rdy}, 32'd0);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, o_done_pls}, 32'd0);
        chk({tag, "_res"},  32'(o_res), 32'd0);
        chk({tag, "_ovf"},  {31'd0, o_ovf}, 32'd0);
        chk({tag, "_nres"}, 32'(n_res), 32'd0);
        chk({tag, "_novf"}, {31'd0, n_ovf}, 32'd0);
    endtask

    task automatic run_op(input bit mode, input int gap_max, input bit mid_start, input bit start_with_vld);
        longint      sum;
        logic [31:0] exp_m, exp_n;
        logic        ov_m, ov_n;
        int          lat;
        int          gap;
        sum = 0;
        for (int k = 0; k < 4; k++) begin
            sum += mode ? longint'((e1[k]-e2[k])*(e1[k]-e2[k])) : longint'(e1[k]*e2[k]);
        end
        exp_m = reduce(sum, W_M, ov_m);
        exp_n = reduce(sum, W_N, ov_n);

        i_mode      = mode;
        i_start_pls = 1'b1;
        if (start_with_vld) begin
            i_vld = 1'b1; i_num1 = 6'h1f; i_num2 = 6'h1f;
        end
        tick();
        i_start_pls = 1'b0;
        i_vld       = 1'b0;
        chk("busy_after_start", {31'd0, o_busy}, 32'd1);
        chk("ovf_cleared_on_start", {31'd0, n_ovf}, 32'd0);
        chk("res_hold_after_start", 32'(o_res), prev_m);

        for (int k = 0; k < 4; k++) begin
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (mid_start && k == 2 && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) begin
                i_vld  = 1'b0;
                i_num1 = 6'($urandom);
                i_num2 = 6'($urandom);
                if (mid_start && k == 2 && g == 0) i_start_pls = 1'b1;
                tick();
                i_start_pls = 1'b0;
                chk("rdy_in_gap", {31'd0, o_rdy}, 32'd1);
            end
            i_vld  = 1'b1;
            i_num1 = 6'(e1[k]);
            i_num2 = 6'(e2[k]);
            chk("rdy_before_accept", {31'd0, o_rdy}, 32'd1);
            tick();
        end

        // Keep offering junk during drain; none of it may be taken.
        i_num1 = 6'h1f;
        i_num2 = 6'h20;
        chk("rdy_drop_after_last", {31'd0, o_rdy}, 32'd0);
        lat = 1;
        while (!o_done_pls && lat < 20) begin
            tick();
            lat++;
        end
        i_vld = 1'b0;
        chk("done_latency", 32'(lat), 32'd4);
        chk("busy_in_done", {31'd0, o_busy}, 32'd1);
        chk("res_main", 32'(o_res), exp_m);
        chk("ovf_main", {31'd0, o_ovf}, {31'd0, ov_m});
        chk("res_narrow", 32'(n_res), exp_n);
        chk("ovf_narrow", {31'd0, n_ovf}, {31'd0, ov_n});
        tick();
        chk("done_one_cycle", {31'd0, o_done_pls}, 32'd0);
        chk("idle_not_busy", {31'd0, o_busy}, 32'd0);
        chk("res_hold_idle", 32'(o_res), exp_m);
        prev_m = exp_m;
    endtask

    task automatic set_all(input int a, input int b);
        for (int k = 0; k < 4; k++) begin
            e1[k] = a; e2[k] = b;
        end
    endtask

    initial begin
        int done_seen;
        sw_rst = 1'b1; i_start_pls = 1'b0; i_mode = 1'b0; i_vld = 1'b0;
        i_num1 = '0; i_num2 = '0;
        prev_m = 32'd0;
        tick();
        tick();
        check_all_zero("reset");
        sw_rst = 1'b0;
        tick();

        // Dot product 4 x (0.5 * 0.5) = 1.0
        set_all(16, 16);
        run_op(1'b0, 0, 1'b0, 1'b0);

        // Squared distance 4 x (-1 - 0.96875)^2; narrow instance overflows
        set_all(-32, 31);
        run_op(1'b1, 0, 1'b0, 1'b0);

        // Mid-operation reset after the 2nd accept
        i_mode = 1'b0; i_start_pls = 1'b1;
        tick();
        i_start_pls = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_vld = 1'b1; i_num1 = 6'h10; i_num2 = 6'h10;
            tick();
        end
        i_vld  = 1'b0;
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        check_all_zero("midrst");
        done_seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (o_done_pls) done_seen++;
        end
        chk("midrst_no_done", 32'(done_seen), 32'd0);
        prev_m = 32'd0;

        set_all(16, 16);
        run_op(1'b0, 0, 1'b0, 1'b0);

        // Gapped dot with an ignored mid-run start: -6+0+9+20 = 23
        e1[0] = 2;  e2[0] = -3;
        e1[1] = 0;  e2[1] = -3;
        e1[2] = -3; e2[2] = -3;
        e1[3] = 4;  e2[3] = 5;
        run_op(1'b0, 3, 1'b1, 1'b0);

        // Start and i_vld in the same IDLE cycle: that element is dropped
        set_all(16, 16);
        run_op(1'b0, 0, 1'b0, 1'b1);

        // Randomized operations in both modes
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) begin
                e1[k] = int'($urandom_range(0, 63)) - 32;
                e2[k] = int'($urandom_range(0, 63)) - 32;
            end
            run_op(1'($urandom), 2, 1'b0, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
